// File: rtl/imm_field_stage.sv
// imm_field_stage: decode-path stage that pulls the scattered RV32I
// immediate into a right-aligned 21-bit field behind a 2-entry skid buffer.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   flush            synchronous discard of all held entries
//   in_valid/ready   upstream handshake, in_instr/in_pc payload
//   out_valid/ready  downstream handshake
//   out_instr/pc     head instruction and PC
//   out_imm21        immediate field, bit 20 is the sign
//   out_fmt          0 R, 1 I, 2 S, 3 B, 4 J, 5 U, 7 unknown
//   out_illegal      unknown-opcode flag
//
// Build option: define IMM_ILLEGAL_DETECT_EN to flag unknown opcodes
// (fmt 7, illegal 1, imm 0). Otherwise they decode as I-format.

module imm_field_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [20:0] out_imm21,
   output logic [2:0]  out_fmt,
   output logic        out_illegal
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_J = 3'd4;
   localparam logic [2:0] FMT_U = 3'd5;
   localparam logic [2:0] FMT_X = 3'd7;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [20:0] imm;
      logic [2:0]  fmt;
`ifdef IMM_ILLEGAL_DETECT_EN
      logic        ill;
`endif
   } ent_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t state;
   ent_t   head;
   ent_t   skid;
   ent_t   dec;

   logic [6:0]  op;
   logic [20:0] imm_i;
   logic [20:0] imm_s;
   logic [20:0] imm_b;
   logic [20:0] imm_j;
   logic        accept;
   logic        pop;

   assign op = in_instr[6:0];

   assign imm_i = {{9{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{9{in_instr[31]}}, in_instr[31:25],
                   in_instr[11:7]};
   assign imm_b = {{8{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_j = {in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

   always_comb begin
      dec       = '0;
      dec.instr = in_instr;
      dec.pc    = in_pc;
      unique case (1'b1)
         (op == OP_OP): begin
            dec.fmt = FMT_R;
         end
         (op == OP_IMM),
         (op == OP_LOAD),
         (op == OP_JALR): begin
            dec.fmt = FMT_I;
            dec.imm = imm_i;
         end
         (op == OP_STORE): begin
            dec.fmt = FMT_S;
            dec.imm = imm_s;
         end
         (op == OP_BRANCH): begin
            dec.fmt = FMT_B;
            dec.imm = imm_b;
         end
         (op == OP_JAL): begin
            dec.fmt = FMT_J;
            dec.imm = imm_j;
         end
         (op == OP_LUI),
         (op == OP_AUIPC): begin
            // consumer reads instr[31:12] itself
            dec.fmt = FMT_U;
         end
         default: begin
`ifdef IMM_ILLEGAL_DETECT_EN
            dec.fmt = FMT_X;
            dec.ill = 1'b1;
`else
            dec.fmt = FMT_I;
            dec.imm = imm_i;
`endif
         end
      endcase
   end

   // in_ready comes from registered state only
   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else if (flush) begin
         // data regs keep last values; only state is cleared
         state <= EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  head  <= dec;
                  state <= ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  head  <= dec;
               end else if (accept) begin
                  skid  <= dec;
                  state <= TWO;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  head  <= skid;
                  state <= ONE;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

   assign out_instr = head.instr;
   assign out_pc    = head.pc;
   assign out_imm21 = head.imm;
   assign out_fmt   = head.fmt;

`ifdef IMM_ILLEGAL_DETECT_EN
   assign out_illegal = head.ill;
`else
   assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_imm_field_stage.sv
// tb_imm_field_stage: directed vectors for imm_field_stage.
// Decode, backpressure, flush and async reset.

module tb_imm_field_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [20:0] out_imm21;
   logic [2:0]  out_fmt;
   logic        out_illegal;

   int n_vec;
   int n_bad;

   imm_field_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_imm21   (out_imm21),
      .out_fmt     (out_fmt),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input string tag,
                        input logic [31:0] ins,
                        input logic [31:0] pc,
                        input logic [2:0]  fmt,
                        input logic [20:0] imm,
                        input logic        ill);
      in_valid  = 1'b1;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".instr"}, out_instr, ins);
      chk({tag, ".pc"}, out_pc, pc);
      chk({tag, ".fmt"}, 32'(out_fmt), 32'(fmt));
      chk({tag, ".imm"}, 32'(out_imm21), 32'(imm));
      chk({tag, ".ill"}, 32'(out_illegal), 32'(ill));
      step();
      chk({tag, ".drain"}, 32'(out_valid), 32'd0);
   endtask

   localparam logic [31:0] A = 32'h00500093;
   localparam logic [31:0] B = 32'h00112223;
   localparam logic [31:0] C = 32'h123452B7;
   localparam logic [31:0] Z = 32'hDEADB0B3;

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.ready", 32'(in_ready), 32'd1);
      chk("rst.instr", out_instr, 32'd0);
      chk("rst.pc", out_pc, 32'd0);
      chk("rst.imm", 32'(out_imm21), 32'd0);
      chk("rst.fmt", 32'(out_fmt), 32'd0);
      chk("rst.ill", 32'(out_illegal), 32'd0);

      send1("addi", 32'hFFF00093, 32'h100, 3'd1, 21'h1FFFFF, 1'b0);
      send1("jal", 32'hFFDFF0EF, 32'h104, 3'd4, 21'h1FFFFC, 1'b0);
      send1("beq", 32'h00000463, 32'h108, 3'd3, 21'h000008, 1'b0);
      send1("sw", B, 32'h10C, 3'd2, 21'h000004, 1'b0);
      send1("lui", C, 32'h110, 3'd5, 21'h0, 1'b0);
      send1("add", 32'h002081B3, 32'h114, 3'd0, 21'h0, 1'b0);
`ifdef IMM_ILLEGAL_DETECT_EN
      send1("illop", 32'h0000007F, 32'h118, 3'd7, 21'h0, 1'b1);
`else
      send1("illop", 32'h0000007F, 32'h118, 3'd1, 21'h0, 1'b0);
`endif

      // backpressure: A, B accepted, C held upstream
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = A;
      in_pc     = 32'h200;
      chk("bp.rdy0", 32'(in_ready), 32'd1);
      step();
      chk("bp.vA", 32'(out_valid), 32'd1);
      chk("bp.hA", out_instr, A);
      chk("bp.rdy1", 32'(in_ready), 32'd1);
      in_instr = B;
      in_pc    = 32'h204;
      step();
      chk("bp.rdy2", 32'(in_ready), 32'd0);
      chk("bp.hA2", out_instr, A);
      in_instr = C;
      in_pc    = 32'h208;
      step();
      chk("bp.rdy3", 32'(in_ready), 32'd0);
      chk("bp.hA3", out_instr, A);
      out_ready = 1'b1;
      step();
      chk("bp.oB", out_instr, B);
      chk("bp.oBpc", out_pc, 32'h204);
      chk("bp.oBimm", 32'(out_imm21), 32'h4);
      chk("bp.rdy4", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp.oC", out_instr, C);
      chk("bp.vC", 32'(out_valid), 32'd1);
      chk("bp.oCfmt", 32'(out_fmt), 32'd5);
      step();
      chk("bp.end", 32'(out_valid), 32'd0);

      // flush with the stage full and an input presented
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = A;
      step();
      in_instr = B;
      step();
      chk("fl.full", 32'(in_ready), 32'd0);
      in_instr = Z;
      flush    = 1'b1;
      step();
      flush = 1'b0;
      chk("fl.valid", 32'(out_valid), 32'd0);
      chk("fl.ready", 32'(in_ready), 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("fl.noZ", 32'(out_valid), 32'd0);
      send1("fl.next", C, 32'h300, 3'd5, 21'h0, 1'b0);

      // async reset with two entries held
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFFF00093;
      in_pc     = 32'h400;
      step();
      in_instr = 32'hFFDFF0EF;
      step();
      in_valid = 1'b0;
      chk("ar.full", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.valid", 32'(out_valid), 32'd0);
      chk("ar.instr", out_instr, 32'd0);
      chk("ar.pc", out_pc, 32'd0);
      chk("ar.imm", 32'(out_imm21), 32'd0);
      chk("ar.fmt", 32'(out_fmt), 32'd0);
      chk("ar.rdy", 32'(in_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step();
      chk("ar.hold", 32'(out_valid), 32'd0);
      send1("ar.after", 32'h00000463, 32'h500, 3'd3, 21'h8, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/imm_field_stage.md
# imm_field_stage

Registered immediate-field extraction stage between instruction fetch and the 21-bit sign extender in the decode path. It accepts fetched instructions over a valid/ready handshake and classifies each by opcode. It gathers that format's scattered immediate bits into a right-aligned 21-bit field whose sign bit is bit 20, and presents the result through a two-entry skid buffer. This gives full throughput under backpressure and a synchronous flush for branch redirects.

## Interface
- No parameters; all widths fixed (RV32I).
- `clk` input 1 — rising-edge clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `flush` input 1 — synchronous discard of all held entries.
- `in_valid` input 1 — upstream instruction valid.
- `in_ready` output 1 — stage can accept this cycle.
- `in_instr` input 32 — fetched instruction.
- `in_pc` input 32 — PC of `in_instr`.
- `out_valid` output 1 — head entry valid.
- `out_ready` input 1 — downstream accepts head.
- `out_instr` output 32 — head instruction.
- `out_pc` output 32 — head PC.
- `out_imm21` output 21 — extracted immediate, bit 20 = sign, feeds the sign extender.
- `out_fmt` output 3 — format code: 0 R, 1 I, 2 S, 3 B, 4 J, 5 U, 7 unknown.
- `out_illegal` output 1 — unknown opcode flag (see Configuration).

## Operation
- Decode is combinational on the input side. Each buffer entry stores {instr, pc, imm21, fmt, illegal}.
- Opcode map (`instr[6:0]`):
  - R: 0110011.
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - J: 1101111.
  - U: 0110111, 0010111.
  - Anything else: unknown.
- Extraction rules, where i = instr:
  - I: {9{i[31]}, i[31:20]}.
  - S: {9{i[31]}, i[31:25], i[11:7]}.
  - B: {8{i[31]}, i[31], i[7], i[30:25], i[11:8], 1'b0}.
  - J: {i[31], i[19:12], i[20], i[30:21], 1'b0}.
  - R, U, unknown: 21'h0. For U-type the consumer takes `instr[31:12]` directly.
- Buffer FSM states:
  - EMPTY: `out_valid`=0.
  - ONE: head only.
  - TWO: head plus skid.
- `in_ready` = (state != TWO). It is a function of registered state only and never depends combinationally on `out_ready`.
- Transfers:
  - Accept = `in_valid & in_ready`.
  - Pop = `out_valid & out_ready`.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept & !pop → TWO.
  - ONE + pop & !accept → EMPTY.
  - ONE + accept & pop → ONE, head replaced by the new entry.
  - TWO + pop → ONE, skid entry moves to head. No accept is possible in TWO.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- `flush`:
  - Next state is EMPTY regardless of the other inputs.
  - An input presented in the flush cycle is discarded.
  - A pop in the flush cycle still counts as consumed by downstream.
- Outputs come from head-entry registers. When EMPTY, the data outputs hold their last values; only `out_valid` is meaningful.

## Timing
- Latency: an entry accepted at edge N appears with `out_valid`=1 after edge N. That is one cycle when the stage is empty.
- Throughput: one instruction per cycle while `out_ready`=1.
- Reset (asynchronous assert, release synchronous to `clk` by the surrounding design):
  - State EMPTY.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_imm21`=0, `out_fmt`=0, `out_illegal`=0.
  - `in_ready`=1.
- Reset mid-operation: all held entries are lost immediately, with no partial outputs.
- `flush` together with `rst_n` low: reset dominates.

## Configuration
- Macro `IMM_ILLEGAL_DETECT_EN`.
- Defined:
  - Unknown opcodes give `out_fmt`=7, `out_illegal`=1, `out_imm21`=0.
  - The entry still flows through the buffer normally.
- Undefined:
  - Unknown opcodes decode as I-format: `out_fmt`=1, with I-rule extraction.
  - `out_illegal` is tied to 0 and no illegal flag bit is stored.

## Test plan
- `addi x1,x0,-1` (0xFFF00093), pc 0x100, `out_ready`=1 → one cycle later: `out_valid`=1, fmt 1, imm21 0x1FFFFF, pc 0x100.
- `jal x1,-4` (0xFFDFF0EF) → fmt 4, imm21 0x1FFFFC. `beq x0,x0,+8` (0x00000463) → fmt 3, imm21 0x000008.
- Backpressure:
  - Stimulus: stream A, B, C with `in_valid`=1, `out_ready`=0 for 3 cycles, then 1.
  - Required: `in_ready` drops after B is accepted, and C is held upstream. After release, A, B, C are output on consecutive cycles in order.
- Flush:
  - Stimulus: assert `flush` with the stage in TWO and `in_valid`=1.
  - Required: next cycle `out_valid`=0, `in_ready`=1, and the flushed input never appears.
- Illegal opcode 0x0000007F:
  - With the macro: fmt 7, illegal 1, imm21 0.
  - Without the macro: fmt 1, illegal 0, imm21 0.
- Async reset asserted mid-clock with two entries held → `out_valid`=0 and all outputs 0 immediately, without waiting for a clock edge. After release the stage accepts normally.
